// File: rtl/game_session_ctrl.sv
// ---------------------------------------------------------------------------
// game_session_ctrl
//
// Session FSM gating in-game functions after login. Sits under the access
// controller next to the authentication block and drives one-cycle event
// pulses, enables, difficulty, lives and a mode code to the game datapath.
//
// Optional feature macro: GAME_SESSION_PAUSE_EN
//   defined   : PauseBtn port exists, PAUSE state (Mode 7) available.
//   undefined : no PauseBtn port, Mode never reaches 7.
//
// Parameters
//   DIFF_W       width of Difficulty
//   MAX_DIFF     difficulty saturation value (< 2**DIFF_W)
//   LIVES        lives per game (>= 1)
//   DISP_SECS    OneSecPulse count spent in GBL_DISP / PASS / FAIL
//   LOGOUT_HOLD  Clk cycles spent in LOGOUT before NewGamePulse (>= 1)
//
// Ports
//   Clk                in   system clock, rising edge
//   Reset              in   synchronous active-high reset
//   Authenticated      in   level, login accepted (sampled only in IDLE)
//   GameStartBtn       in   one-cycle press
//   LogOutBtn          in   one-cycle press
//   PauseBtn           in   one-cycle press (GAME_SESSION_PAUSE_EN only)
//   CrashDetected      in   level, player collision
//   LEDTrackerTimeOut  in   level, round survived
//   OneSecPulse        in   one-cycle 1 Hz strobe
//   NewGamePulse       out  new session / clear scores
//   PassedRoundPulse   out  round passed
//   GameOverPulse      out  round start or final life lost
//   LogOutPulse        out  logout accepted
//   EnableGameElements out  level, asteroids/player active
//   EnableTimer        out  level, session timer runs
//   Difficulty         out  current level
//   LivesLeft          out  remaining lives
//   Mode               out  0 IDLE,1 GBL_DISP,2 PER_DISP,3 PASS,4 FAIL,
//                           5 PLAY,6 LOGOUT,7 PAUSE
// ---------------------------------------------------------------------------
module game_session_ctrl #(
  parameter int unsigned DIFF_W      = 2,
  parameter int unsigned MAX_DIFF    = 3,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned DISP_SECS   = 5,
  parameter int unsigned LOGOUT_HOLD = 2,
  localparam int unsigned LIVES_W    = $clog2(LIVES + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Authenticated,
  input  logic               GameStartBtn,
  input  logic               LogOutBtn,
`ifdef GAME_SESSION_PAUSE_EN
  input  logic               PauseBtn,
`endif
  input  logic               CrashDetected,
  input  logic               LEDTrackerTimeOut,
  input  logic               OneSecPulse,
  output logic               NewGamePulse,
  output logic               PassedRoundPulse,
  output logic               GameOverPulse,
  output logic               LogOutPulse,
  output logic               EnableGameElements,
  output logic               EnableTimer,
  output logic [DIFF_W-1:0]  Difficulty,
  output logic [LIVES_W-1:0] LivesLeft,
  output logic [2:0]         Mode
);

  // One counter serves both the display-second count and the logout hold.
  localparam int unsigned CNT_MAX = (DISP_SECS > LOGOUT_HOLD) ? DISP_SECS : LOGOUT_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   DISP_CNT   = CNT_W'(DISP_SECS);
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(LOGOUT_HOLD - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [DIFF_W-1:0]  DIFF_MAX   = DIFF_W'(MAX_DIFF);

  // Encodings equal the Mode output code, so Mode is the state register.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GBL_DISP = 3'd1,
    S_PER_DISP = 3'd2,
    S_PASS     = 3'd3,
    S_FAIL     = 3'd4,
    S_PLAY     = 3'd5,
    S_LOGOUT   = 3'd6
`ifdef GAME_SESSION_PAUSE_EN
    ,S_PAUSE   = 3'd7
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               new_game_q, new_game_d;
  logic               passed_q, passed_d;
  logic               over_q, over_d;
  logic               logout_q, logout_d;
  logic               en_game_q, en_game_d;
  logic               en_timer_q, en_timer_d;
  logic               go_logout;

  assign cnt_inc = cnt_q + 1'b1;

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    diff_d     = diff_q;
    lives_d    = lives_q;
    new_game_d = 1'b0;
    passed_d   = 1'b0;
    over_d     = 1'b0;
    logout_d   = 1'b0;
    go_logout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (Authenticated) begin
          state_d    = S_GBL_DISP;
          new_game_d = 1'b1;
        end
      end

      S_GBL_DISP, S_PASS, S_FAIL: begin
        // Logout wins over an expiring display on the same cycle.
        if (LogOutBtn) begin
          go_logout = 1'b1;
        end else if (OneSecPulse) begin
          if (cnt_inc == DISP_CNT) begin
            cnt_d = '0;
            if (state_q == S_GBL_DISP) begin
              state_d = S_PER_DISP;
            end else if (state_q == S_PASS) begin
              state_d = S_PER_DISP;
              if (diff_q < DIFF_MAX) begin
                diff_d = diff_q + 1'b1;
              end
            end else if (lives_q != '0) begin
              state_d = S_PER_DISP;
            end else begin
              // Last life spent: restart the game from the global display.
              state_d = S_GBL_DISP;
              diff_d  = '0;
              lives_d = LIVES_INIT;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_PER_DISP: begin
        if (GameStartBtn) begin
          state_d = S_PLAY;
          over_d  = 1'b1;
        end else if (LogOutBtn) begin
          go_logout = 1'b1;
        end
      end

      S_PLAY: begin
        // LogOutBtn deliberately not examined while playing.
        if (LEDTrackerTimeOut) begin
          state_d  = S_PASS;
          passed_d = 1'b1;
          cnt_d    = '0;
        end else if (CrashDetected) begin
          state_d = S_FAIL;
          cnt_d   = '0;
          if (lives_q != '0) begin
            lives_d = lives_q - 1'b1;
          end
          if (lives_q <= LIVES_W'(1)) begin
            over_d = 1'b1;
          end
        end
`ifdef GAME_SESSION_PAUSE_EN
        else if (PauseBtn) begin
          state_d = S_PAUSE;
        end
`endif
      end

      S_LOGOUT: begin
        diff_d  = '0;
        lives_d = LIVES_INIT;
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          new_game_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef GAME_SESSION_PAUSE_EN
      S_PAUSE: begin
        if (PauseBtn) begin
          state_d = S_PLAY;
        end else if (LogOutBtn) begin
          go_logout = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Common LOGOUT entry shared by every state that accepts a logout.
    if (go_logout) begin
      state_d  = S_LOGOUT;
      logout_d = 1'b1;
      cnt_d    = HOLD_LOAD;
      diff_d   = '0;
      lives_d  = LIVES_INIT;
    end

    en_game_d  = (state_d == S_PLAY);
`ifdef GAME_SESSION_PAUSE_EN
    en_timer_d = (state_d != S_IDLE) && (state_d != S_PAUSE);
`else
    en_timer_d = (state_d != S_IDLE);
`endif
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      diff_q     <= '0;
      lives_q    <= LIVES_INIT;
      new_game_q <= 1'b0;
      passed_q   <= 1'b0;
      over_q     <= 1'b0;
      logout_q   <= 1'b0;
      en_game_q  <= 1'b0;
      en_timer_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      diff_q     <= diff_d;
      lives_q    <= lives_d;
      new_game_q <= new_game_d;
      passed_q   <= passed_d;
      over_q     <= over_d;
      logout_q   <= logout_d;
      en_game_q  <= en_game_d;
      en_timer_q <= en_timer_d;
    end
  end

  assign NewGamePulse       = new_game_q;
  assign PassedRoundPulse   = passed_q;
  assign GameOverPulse      = over_q;
  assign LogOutPulse        = logout_q;
  assign EnableGameElements = en_game_q;
  assign EnableTimer        = en_timer_q;
  assign Difficulty         = diff_q;
  assign LivesLeft          = lives_q;
  assign Mode               = state_q;

endmodule
